// File: rtl/ocram_byte_array.sv
// ocram_byte_array: byte-wide single-port on-chip RAM behind the APB SRAM
// controller. Adds a zero-fill init engine, an address-window check and
// per-byte even parity with a sticky error flag.
module ocram_byte_array #(
   parameter int                    ADDR_WIDTH    = 32,
   parameter int                    DEPTH_LOG2    = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter bit                    INIT_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sram_cs,
   input  logic                  sram_we,
   input  logic [ADDR_WIDTH-1:0] sram_addr,
   input  logic [7:0]            sram_din,
   output logic [7:0]            sram_dout,
   output logic                  init_busy,
   output logic                  oor_err,
   output logic                  par_err,
   input  logic                  err_clr,
   input  logic                  inj_par
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_INIT = 1'b1
   } state_t;

   state_t                  state;
   logic [DEPTH_LOG2-1:0]   cnt;

   logic [7:0]              mem     [DEPTH];
   logic                    par_mem [DEPTH];

   logic [ADDR_WIDTH-1:0]   off;
   logic                    in_win;
   logic [DEPTH_LOG2-1:0]   idx;
   logic                    idle;
   logic                    init_wr;
   logic                    acc_wr;
   logic                    acc_rd;
   logic                    mem_we;
   logic [DEPTH_LOG2-1:0]   mem_addr;
   logic [7:0]              mem_wdata;
   logic                    mem_wpar;
   logic [7:0]              rd_data;
   logic                    rd_bad;

   // Address decode, access qualification and the init/access write-port mux.
   // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
   always_comb begin
      off       = sram_addr - BASE_ADDR;
      in_win    = (off[ADDR_WIDTH-1:DEPTH_LOG2] == '0);
      idx       = off[DEPTH_LOG2-1:0];
      idle      = (state == ST_IDLE);
      init_wr   = !rst && (state == ST_INIT);
      acc_wr    = !rst && idle && sram_cs && sram_we && in_win;
      acc_rd    = idle && sram_cs && !sram_we && in_win;
      // The init engine owns the single write port while it runs.
      mem_we    = init_wr || acc_wr;
      mem_addr  = init_wr ? cnt : idx;
      mem_wdata = init_wr ? 8'h00 : sram_din;
      mem_wpar  = init_wr ? 1'b0 : ((^sram_din) ^ inj_par);
      rd_data   = mem[idx];
      rd_bad    = ((^rd_data) != par_mem[idx]);
   end

   // Storage write port shared by the zero-fill engine and normal writes.
   // NOTE: the arrays carry no reset so they map onto RAM; clearing is the init engine's job.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr]     <= mem_wdata;
         par_mem[mem_addr] <= mem_wpar;
      end
   end

   // Init FSM, registered read data and error flags.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
         cnt       <= '0;
         sram_dout <= 8'h00;
         oor_err   <= 1'b0;
         par_err   <= 1'b0;
      end else begin
         oor_err <= idle && sram_cs && !in_win;

         case (state)
            ST_INIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == '1) begin
                  state <= ST_IDLE;
               end
               // Reads that slip in during init see zeros, not stale contents.
               if (sram_cs && !sram_we) begin
                  sram_dout <= 8'h00;
               end
            end
            ST_IDLE: begin
               if (sram_cs && !sram_we) begin
                  sram_dout <= in_win ? rd_data : 8'h00;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // A new error wins over a clear in the same cycle.
         if (acc_rd && rd_bad) begin
            par_err <= 1'b1;
         end else if (err_clr) begin
            par_err <= 1'b0;
         end
      end
   end

   assign init_busy = (state == ST_INIT);

endmodule

// File: tb/tb_ocram_byte_array.sv
// tb_ocram_byte_array: directed bench for ocram_byte_array with a 16-byte
// array mapped at 0x1000. Expected results are queued as stimulus is driven
// and compared when the DUT output for that cycle is sampled.
module tb_ocram_byte_array;

   localparam int          AW   = 32;
   localparam int          DL   = 4;
   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        sram_cs   = 1'b0;
   logic        sram_we   = 1'b0;
   logic [31:0] sram_addr = '0;
   logic [7:0]  sram_din  = '0;
   logic        err_clr   = 1'b0;
   logic        inj_par   = 1'b0;
   logic [7:0]  sram_dout;
   logic        init_busy;
   logic        oor_err;
   logic        par_err;

   ocram_byte_array #(
      .ADDR_WIDTH    (AW),
      .DEPTH_LOG2    (DL),
      .BASE_ADDR     (BASE),
      .INIT_ON_RESET (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sram_cs   (sram_cs),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_dout (sram_dout),
      .init_busy (init_busy),
      .oor_err   (oor_err),
      .par_err   (par_err),
      .err_clr   (err_clr),
      .inj_par   (inj_par)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      bit         chk_d;
      logic [7:0] d;
      logic       oor;
      logic       pe;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] hold  = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input string tag, input bit cs, input bit we, input logic [31:0] addr,
                        input logic [7:0] din, input bit inj, input bit clr,
                        input bit chk_d, input logic [7:0] d, input bit oor, input bit pe);
      exp_t e;
      sram_cs   = cs;
      sram_we   = we;
      sram_addr = addr;
      sram_din  = din;
      inj_par   = inj;
      err_clr   = clr;
      e.tag = tag; e.chk_d = chk_d; e.d = d; e.oor = oor; e.pe = pe;
      sb.push_back(e);
      step();
      sram_cs = 1'b0; sram_we = 1'b0; inj_par = 1'b0; err_clr = 1'b0;
      e = sb.pop_front();
      if (e.chk_d) check({e.tag, ":dout"}, 32'(sram_dout), 32'(e.d));
      check({e.tag, ":oor"}, 32'(oor_err), 32'(e.oor));
      check({e.tag, ":par_err"}, 32'(par_err), 32'(e.pe));
   endtask

   task automatic wr(input string tag, input logic [31:0] addr, input logic [7:0] din,
                     input bit inj, input bit oor, input bit pe);
      drive(tag, 1'b1, 1'b1, addr, din, inj, 1'b0, 1'b1, hold, oor, pe);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [7:0] d,
                     input bit oor, input bit pe);
      hold = d;
      drive(tag, 1'b1, 1'b0, addr, 8'h00, 1'b0, 1'b0, 1'b1, d, oor, pe);
   endtask

   task automatic nop(input string tag, input bit clr, input bit pe);
      drive(tag, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, clr, 1'b1, hold, 1'b0, pe);
   endtask

   // Counts cycles with init_busy high after rst drops; optionally pokes accesses mid-init.
   task automatic init_count(input string tag, input bit poke);
      int cnt      = 0;
      bit seen_oor = 1'b0;
      bit seen_pe  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!init_busy) break;
         cnt++;
         sram_cs = 1'b0;
         sram_we = 1'b0;
         if (poke && i == 2) begin
            sram_cs = 1'b1; sram_we = 1'b1; sram_addr = BASE + 32'h5; sram_din = 8'hFF;
         end else if (poke && i == 3) begin
            sram_cs = 1'b1; sram_addr = BASE + 32'h5;
         end else if (poke && i == 4) begin
            sram_cs = 1'b1; sram_addr = 32'h0000_0FFF;
         end
         step();
         seen_oor |= oor_err;
         seen_pe  |= par_err;
      end
      sram_cs = 1'b0;
      sram_we = 1'b0;
      check({tag, ":busy_cycles"}, 32'(cnt), 32'd16);
      check({tag, ":no_oor_in_init"}, 32'(seen_oor), 32'd0);
      check({tag, ":no_pe_in_init"}, 32'(seen_pe), 32'd0);
      check({tag, ":dout_after_init"}, 32'(sram_dout), 32'h00);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state.
      rst = 1'b1;
      repeat (3) step();
      check("rst:dout", 32'(sram_dout), 32'h00);
      check("rst:oor", 32'(oor_err), 32'd0);
      check("rst:par_err", 32'(par_err), 32'd0);
      check("rst:init_busy", 32'(init_busy), 32'd1);

      // Zero-fill with a write, a read and an out-of-window read during init.
      rst = 1'b0;
      init_count("init", 1'b1);
      hold = 8'h00;
      for (int i = 0; i < 16; i++) rd($sformatf("zero%0d", i), BASE + 32'(i), 8'h00, 1'b0, 1'b0);

      // Write/read, including read-after-write on the next cycle.
      wr("w3", BASE + 32'h3, 8'hA5, 1'b0, 1'b0, 1'b0);
      wr("w4", BASE + 32'h4, 8'h3C, 1'b0, 1'b0, 1'b0);
      rd("r3", BASE + 32'h3, 8'hA5, 1'b0, 1'b0);
      rd("r4", BASE + 32'h4, 8'h3C, 1'b0, 1'b0);
      wr("w7", BASE + 32'h7, 8'h77, 1'b0, 1'b0, 1'b0);
      rd("r7", BASE + 32'h7, 8'h77, 1'b0, 1'b0);
      wr("w0", BASE + 32'h0, 8'hC3, 1'b0, 1'b0, 1'b0);
      wr("wF", BASE + 32'hF, 8'h5A, 1'b0, 1'b0, 1'b0);
      nop("hold", 1'b0, 1'b0);

      // Address window: below, above, wrapped; dropped write must not alias idx 0.
      rd("oor_lo", 32'h0000_0FFF, 8'h00, 1'b1, 1'b0);
      wr("oor_hi", 32'h0000_1010, 8'h55, 1'b0, 1'b1, 1'b0);
      nop("oor_gap", 1'b0, 1'b0);
      rd("oor_wrap", 32'h0000_0000, 8'h00, 1'b1, 1'b0);
      rd("r0", BASE + 32'h0, 8'hC3, 1'b0, 1'b0);
      rd("rF", BASE + 32'hF, 8'h5A, 1'b0, 1'b0);

      // Parity injection, stickiness, clear, set-beats-clear.
      wr("inj", BASE + 32'h2, 8'h01, 1'b1, 1'b0, 1'b0);
      rd("pe_set", BASE + 32'h2, 8'h01, 1'b0, 1'b1);
      rd("pe_sticky", BASE + 32'h3, 8'hA5, 1'b0, 1'b1);
      rd("pe_oor", 32'h0000_2000, 8'h00, 1'b1, 1'b1);
      nop("pe_clr", 1'b1, 1'b0);
      nop("pe_stay_clr", 1'b0, 1'b0);
      hold = 8'h01;
      drive("pe_set_vs_clr", 1'b1, 1'b0, BASE + 32'h2, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1);
      nop("pe_hold", 1'b0, 1'b1);
      hold = 8'hA5;
      drive("pe_clr_on_read", 1'b1, 1'b0, BASE + 32'h3, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
      rd("pe_reset_src", BASE + 32'h2, 8'h01, 1'b0, 1'b1);

      // Reset clears flags and read data, then restart init mid-way.
      rst = 1'b1;
      step();
      check("rst2:dout", 32'(sram_dout), 32'h00);
      check("rst2:par_err", 32'(par_err), 32'd0);
      check("rst2:init_busy", 32'(init_busy), 32'd1);
      rst = 1'b0;
      repeat (7) step();
      check("mid:init_busy", 32'(init_busy), 32'd1);
      rst = 1'b1;
      step();
      check("mid_rst:init_busy", 32'(init_busy), 32'd1);
      rst = 1'b0;
      init_count("reinit", 1'b0);
      hold = 8'h00;
      for (int i = 0; i < 16; i++) rd($sformatf("rezero%0d", i), BASE + 32'(i), 8'h00, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
